fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum consecutive WAIT cycles before a fetch error (legal range 1..255).
REQ-003 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset, input, 1, a synchronous active-low reset: reset==0 at a rising edge of clock resets the block.
REQ-005 SHALL have port branch_taken, input, 1, the EX/MEM redirect request.
REQ-006 SHALL have port branch_target, input, 32, the EX/MEM redirect address.
REQ-007 SHALL have port hazard_stall, input, 1, the load-use stall request from hazard detection.
REQ-008 SHALL have port imem_ready, input, 1, meaning instruction memory data is valid this cycle.
REQ-009 SHALL have port pc_out, output, 32, the registered fetch address driven to instruction memory.
REQ-010 SHALL have port imem_req, output, 1, the fetch request.
REQ-011 SHALL have port pc_write, output, 1, meaning the PC changes at the next edge.
REQ-012 SHALL have port ifid_write, output, 1, the IF/ID register load enable.
REQ-013 SHALL have port ifid_flush, output, 1, meaning the IF/ID register is cleared to a bubble at the next edge.
REQ-014 SHALL have port fetch_error, output, 1, a sticky fault flag.
REQ-015 SHALL have port flush_count, output, 16, the number of redirects taken, saturating.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT and HALT, encoded in a 2-bit register.
REQ-017 SHALL drive pc_write, ifid_write and ifid_flush combinationally from the current state and inputs; all other outputs SHALL be registered.
REQ-018 IDLE SHALL:
- drive imem_req=0, pc_write=0, ifid_write=0, ifid_flush=1;
- transition unconditionally to FETCH on the next edge.
REQ-019 FETCH and WAIT SHALL drive imem_req=1 and apply input priority: branch_taken > hazard_stall > imem_ready.
REQ-020 Redirect (branch_taken=1, branch_target[1:0]==0) in FETCH or WAIT SHALL:
- load pc_out<=branch_target with pc_write=1, ifid_flush=1, ifid_write=0;
- increment flush_count, saturating at 16'hFFFF;
- clear the wait counter and go to FETCH.
REQ-021 A misaligned redirect (branch_taken=1, branch_target[1:0]!=0) SHALL leave pc_out unchanged, assert fetch_error and go to HALT.
REQ-022 Stall (hazard_stall=1, no redirect) SHALL hold pc_out with pc_write=0, ifid_write=0, ifid_flush=0, and leave the state unchanged.
REQ-023 FETCH with imem_ready=1 and no redirect or stall SHALL:
- load pc_out<=pc_out+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0);
- drive pc_write=1, ifid_write=1;
- remain in FETCH.
REQ-024 FETCH with imem_ready=0 and no redirect or stall SHALL go to WAIT with wait counter=1, pc_write=0, ifid_write=0.
REQ-025 WAIT with imem_ready=1 and no redirect or stall SHALL behave as REQ-023, then go to FETCH.
REQ-026 WAIT with imem_ready=0 and no redirect SHALL:
- increment the wait counter;
- when the counter equals MEM_TIMEOUT, go to HALT and assert fetch_error at that edge.
REQ-027 A stall in WAIT SHALL not reset the wait counter.
REQ-028 HALT SHALL:
- drive imem_req=0, pc_write=0, ifid_write=0, ifid_flush=1;
- ignore all inputs;
- keep fetch_error=1 until reset.
REQ-029 pc_write and ifid_write SHALL never both be 1 while ifid_flush=1, except none — on redirect ifid_write=0 always.

Reset
REQ-030 On reset==0 at a rising edge, the block SHALL enter IDLE and set pc_out=RESET_PC, imem_req=0, fetch_error=0, flush_count=0, wait counter=0.
REQ-031 Reset SHALL override every input and every state, including mid-WAIT and HALT.
REQ-032 While reset==0, the combinational outputs SHALL read pc_write=0, ifid_write=0, ifid_flush=1.

Verification
REQ-033 Reset release with imem_ready=1 held: expect IDLE for 1 cycle, then pc_out = 0,4,8,12 on successive edges, with ifid_write=1 each FETCH cycle.
REQ-034 Redirect: branch_taken=1, branch_target=32'h0000_0100 during FETCH with hazard_stall=1 -> next pc_out=32'h100, ifid_flush=1 that cycle, flush_count +1.
REQ-035 Memory wait: imem_ready=0 for 3 cycles then 1 -> pc_out holds for 3 cycles, then advances by 4; fetch_error stays 0.
REQ-036 Timeout: imem_ready=0 continuously with MEM_TIMEOUT=15 -> HALT and fetch_error=1 after 16 cycles from FETCH; a later branch_taken is ignored; reset==0 clears it, with pc_out=RESET_PC.
REQ-037 Boundaries:
- pc_out=32'hFFFF_FFFC with imem_ready=1 -> pc_out=0;
- branch_target=32'h102 -> HALT, fetch_error=1;
- 65536 redirects -> flush_count stays 16'hFFFF.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, handshakes with instruction memory,
// applies redirects and load-use stalls, and latches a sticky fault on timeout or bad target.
module fetch_controller #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        fetch_error,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_imem_req;
    logic        r_fetch_error;
    logic [15:0] r_flush_count;
    logic [7:0]  r_wait_cnt;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic        w_imem_req_next;
    logic        w_fetch_error_next;
    logic [15:0] w_flush_count_next;
    logic [7:0]  w_wait_cnt_next;
    logic        w_aligned;

    assign w_aligned = (branch_target[1:0] == 2'b00);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_fetch_error <= 1'b0;
            r_flush_count <= 16'd0;
            r_wait_cnt    <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_imem_req    <= w_imem_req_next;
            r_fetch_error <= w_fetch_error_next;
            r_flush_count <= w_flush_count_next;
            r_wait_cnt    <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_error_next = r_fetch_error;
        w_flush_count_next = r_flush_count;
        w_wait_cnt_next    = r_wait_cnt;
        pc_write           = 1'b0;
        ifid_write         = 1'b0;
        ifid_flush         = 1'b0;

        case (r_state)
            IDLE: begin
                ifid_flush   = 1'b1;
                w_state_next = FETCH;
            end
            FETCH, WAIT: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    if (w_aligned) begin
                        pc_write           = 1'b1;
                        w_pc_next          = branch_target;
                        w_flush_count_next = (r_flush_count == 16'hFFFF) ? r_flush_count
                                                                          : r_flush_count + 16'd1;
                        w_wait_cnt_next    = 8'd0;
                        w_state_next       = FETCH;
                    end else begin
                        w_fetch_error_next = 1'b1;
                        w_state_next       = HALT;
                    end
                end else if (hazard_stall) begin
                    // Stall freezes everything, including a partially elapsed wait count.
                    w_state_next = r_state;
                end else if (imem_ready) begin
                    pc_write        = 1'b1;
                    ifid_write      = 1'b1;
                    w_pc_next       = r_pc + 32'd4;
                    w_wait_cnt_next = 8'd0;
                    w_state_next    = FETCH;
                end else if (r_state == FETCH) begin
                    w_wait_cnt_next = 8'd1;
                    w_state_next    = WAIT;
                end else if (r_wait_cnt == TIMEOUT) begin
                    w_fetch_error_next = 1'b1;
                    w_state_next       = HALT;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 8'd1;
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                ifid_flush   = 1'b1;
                w_state_next = IDLE;
            end
        endcase

        // Reset is synchronous for state, but the pipeline must see a bubble during it.
        if (!reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign w_imem_req_next = (w_state_next == FETCH) || (w_state_next == WAIT);

    assign pc_out      = r_pc;
    assign imem_req    = r_imem_req;
    assign fetch_error = r_fetch_error;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_controller;

    localparam int          TO       = 15;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        hazard_stall;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic        imem_req;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        fetch_error;
    logic [15:0] flush_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fetch_controller #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .branch_taken(branch_taken),
        .branch_target(branch_target), .hazard_stall(hazard_stall),
        .imem_ready(imem_ready), .pc_out(pc_out), .imem_req(imem_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .fetch_error(fetch_error), .flush_count(flush_count)
    );

    // Behavioural model: what the fetch unit is doing, where it is, how long it has waited.
    typedef enum {M_IDLE, M_FETCH, M_WAIT, M_HALT} mmode_t;
    mmode_t      m_mode;
    logic [31:0] m_pc;
    int          m_waits;
    longint      m_flushes;
    bit          m_err;
    bit          e_pw, e_iw, e_fl;
    logic        o_pw, o_iw, o_fl;

    function automatic logic [15:0] exp_flush();
        return (m_flushes > 65535) ? 16'hFFFF : 16'(m_flushes);
    endfunction

    function automatic logic exp_req();
        return (m_mode == M_FETCH) || (m_mode == M_WAIT);
    endfunction

    task automatic model_step(input bit rst, input bit bt, input logic [31:0] tgt,
                              input bit hs, input bit rdy);
        {e_pw, e_iw, e_fl} = 3'b001;
        if (!rst) begin
            m_mode = M_IDLE; m_pc = RST_PC; m_waits = 0; m_flushes = 0; m_err = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_FETCH;
        end else if (m_mode != M_HALT) begin
            if (bt && (tgt % 4 == 0)) begin
                {e_pw, e_iw, e_fl} = 3'b101;
                m_pc = tgt; m_flushes++; m_waits = 0; m_mode = M_FETCH;
            end else if (bt) begin
                m_err = 1; m_mode = M_HALT;
            end else if (hs) begin
                e_fl = 0;
            end else if (rdy) begin
                {e_pw, e_iw, e_fl} = 3'b110;
                m_pc = m_pc + 32'd4; m_waits = 0; m_mode = M_FETCH;
            end else begin
                e_fl = 0;
                if (m_mode == M_FETCH) begin
                    m_mode = M_WAIT; m_waits = 1;
                end else if (m_waits >= TO) begin
                    m_mode = M_HALT; m_err = 1;
                end else begin
                    m_waits++;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, sample the combinational outputs mid-cycle, advance model and clock.
    task automatic drive_cycle(input bit rst, input bit bt, input logic [31:0] tgt,
                               input bit hs, input bit rdy);
        reset = rst; branch_taken = bt; branch_target = tgt;
        hazard_stall = hs; imem_ready = rdy;
        #1;
        o_pw = pc_write; o_iw = ifid_write; o_fl = ifid_flush;
        model_step(rst, bt, tgt, hs, rdy);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            checks++;
            if ({o_pw, o_iw, o_fl} !== 3'b001) begin
                errors++;
                $display("FAIL reset_comb: got pw/iw/fl=%b%b%b want 001", o_pw, o_iw, o_fl);
            end
        end
        checks++;
        if (pc_out !== RST_PC || imem_req !== 1'b0 || fetch_error !== 1'b0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got pc=%h req=%b err=%b fc=%0d want pc=%h req=0 err=0 fc=0",
                     pc_out, imem_req, fetch_error, flush_count, RST_PC);
        end
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        drive_cycle(1, 0, 32'h0, 0, 1);
        checks++;
        if (o_fl !== 1'b1 || o_iw !== 1'b0 || pc_out !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL idle_cycle: got fl=%b iw=%b pc=%h req=%b want fl=1 iw=0 pc=0 req=1",
                     o_fl, o_iw, pc_out, imem_req);
        end
        for (int k = 1; k <= 3; k++) begin
            drive_cycle(1, 0, 32'h0, 0, 1);
            checks++;
            if (o_iw !== 1'b1 || o_pw !== 1'b1 || pc_out !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_fetch%0d: got iw=%b pw=%b pc=%h want iw=1 pw=1 pc=%h",
                         k, o_iw, o_pw, pc_out, 32'(4 * k));
            end
        end
        $display("test_sequential done pc=%h", pc_out);
    endtask

    task automatic test_redirect();
        drive_cycle(1, 1, 32'h0000_0100, 1, 1'($urandom));
        checks++;
        if (o_fl !== 1'b1 || o_iw !== 1'b0 || o_pw !== 1'b1 || pc_out !== 32'h100 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL redirect: got fl=%b iw=%b pw=%b pc=%h fc=%0d want 1 0 1 00000100 1",
                     o_fl, o_iw, o_pw, pc_out, flush_count);
        end
        $display("test_redirect done pc=%h fc=%0d", pc_out, flush_count);
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 32'h0, 0, 0);
            checks++;
            if (pc_out !== 32'h100 || o_iw !== 1'b0 || fetch_error !== 1'b0 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL wait_hold%0d: got pc=%h iw=%b err=%b req=%b want 00000100 0 0 1",
                         i, pc_out, o_iw, fetch_error, imem_req);
            end
        end
        drive_cycle(1, 0, 32'h0, 0, 1);
        checks++;
        if (pc_out !== 32'h104 || o_iw !== 1'b1 || fetch_error !== 1'b0) begin
            errors++;
            $display("FAIL wait_release: got pc=%h iw=%b err=%b want 00000104 1 0", pc_out, o_iw, fetch_error);
        end
        $display("test_mem_wait done pc=%h", pc_out);
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= TO + 1; i++) begin
            drive_cycle(1, 0, 32'h0, 0, 0);
            checks++;
            if (fetch_error !== 1'(i == TO + 1) || imem_req !== 1'(i <= TO) || pc_out !== 32'h104) begin
                errors++;
                $display("FAIL timeout_edge%0d: got err=%b req=%b pc=%h want err=%b req=%b pc=00000104",
                         i, fetch_error, imem_req, pc_out, i == TO + 1, i <= TO);
            end
        end
        drive_cycle(1, 1, 32'h0000_0200, 0, 1);
        checks++;
        if (pc_out !== 32'h104 || fetch_error !== 1'b1 || o_pw !== 1'b0 || o_fl !== 1'b1 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL halt_ignores: got pc=%h err=%b pw=%b fl=%b fc=%0d want 00000104 1 0 1 1",
                     pc_out, fetch_error, o_pw, o_fl, flush_count);
        end
        drive_cycle(0, 0, 32'h0, 0, 0);
        checks++;
        if (pc_out !== RST_PC || fetch_error !== 1'b0 || imem_req !== 1'b0 || flush_count !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: got pc=%h err=%b req=%b fc=%0d want %h 0 0 0",
                     pc_out, fetch_error, imem_req, flush_count, RST_PC);
        end
        $display("test_timeout done");
    endtask

    task automatic test_boundaries();
        drive_cycle(1, 0, 32'h0, 0, 0);
        drive_cycle(1, 1, 32'hFFFF_FFFC, 0, 0);
        drive_cycle(1, 0, 32'h0, 0, 1);
        checks++;
        if (pc_out !== 32'h0 || o_pw !== 1'b1) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h pw=%b want 00000000 1", pc_out, o_pw);
        end
        drive_cycle(1, 1, 32'h0000_0102, 0, 1);
        checks++;
        if (pc_out !== 32'h0 || fetch_error !== 1'b1 || imem_req !== 1'b0 || o_pw !== 1'b0 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL misaligned: got pc=%h err=%b req=%b pw=%b fc=%0d want 00000000 1 0 0 1",
                     pc_out, fetch_error, imem_req, o_pw, flush_count);
        end
        drive_cycle(0, 0, 32'h0, 0, 0);
        $display("test_boundaries done");
    endtask

    task automatic test_random();
        int p_rdy;
        bit rst, bt, hs, rdy;
        logic [31:0] tgt;
        for (int seg = 0; seg < 8; seg++) begin
            p_rdy = $urandom_range(0, 4);
            for (int c = 0; c < 60; c++) begin
                rst = ($urandom % 40) != 0;
                bt  = ($urandom % 8) == 0;
                tgt = $urandom & 32'hFFFF_FFFC;
                if (($urandom % 6) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
                hs  = ($urandom % 4) == 0;
                rdy = int'($urandom % 4) < p_rdy;
                drive_cycle(rst, bt, tgt, hs, rdy);
                checks++;
                if (pc_out !== m_pc || imem_req !== exp_req() || fetch_error !== m_err ||
                    flush_count !== exp_flush() || {o_pw, o_iw, o_fl} !== {e_pw, e_iw, e_fl}) begin
                    errors++;
                    $display("FAIL random s%0d c%0d: got pc=%h req=%b err=%b fc=%0d comb=%b%b%b want pc=%h req=%b err=%b fc=%0d comb=%b%b%b",
                             seg, c, pc_out, imem_req, fetch_error, flush_count, o_pw, o_iw, o_fl,
                             m_pc, exp_req(), m_err, exp_flush(), e_pw, e_iw, e_fl);
                end
            end
        end
        $display("test_random done");
    endtask

    task automatic test_saturation();
        drive_cycle(0, 0, 32'h0, 0, 0);
        drive_cycle(1, 0, 32'h0, 0, 0);
        for (int i = 1; i <= 65540; i++) begin
            drive_cycle(1, 1, $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom));
            if (i == 65534 || i == 65535 || i == 65540) begin
                checks++;
                if (flush_count !== exp_flush() || flush_count !== 16'(i > 65535 ? 65535 : i) || pc_out !== m_pc) begin
                    errors++;
                    $display("FAIL saturate%0d: got fc=%h pc=%h want fc=%h pc=%h",
                             i, flush_count, pc_out, exp_flush(), m_pc);
                end
            end
        end
        $display("test_saturation done fc=%h", flush_count);
    endtask

    initial begin
        reset = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        hazard_stall = 1'b0; imem_ready = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_sequential();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_boundaries();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
